// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package obi_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Width of a requester index: max(1, clog2(n)).
  function automatic int idw_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order ID FIFO recording which requester owns each outstanding transaction.
// Latency: push visible at head on the next cycle; head is a registered read.
// Backpressure: push ignored when full, pop ignored when empty (caller gates both).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_i, data_i        write one ID
//   pop_i                 retire the head entry
//   head_o                oldest ID
//   full_o, empty_o       occupancy flags
//   count_o               number of stored entries
import obi_arb_pkg::*;

module obi_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap keeps non-power-of-two pointer widths safe.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full_o   = (count_q == CW'(DEPTH));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    head_o   = mem_q[rd_ptr_q];
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: NUM_MASTERS requesters share one downstream port; responses routed back in order.
// Latency: 0 cycles req->s_req_o, s_gnt_i->m_gnt_o, s_rvalid_i->m_rvalid_o; one handshake per cycle.
// Backpressure: requester held (HOLD) until s_gnt_i; new requests blocked while MAX_OUTSTANDING IDs pending.
//
// Ports: clk_i/rst_i (sync, active-high); m_* flattened per-requester OBI buses (requester i at slice i);
//        s_* single downstream OBI port; err_o sticky protocol error (only with OBI_ARB_ERR_EN).
// Optional feature macro: OBI_ARB_ERR_EN.
import obi_arb_pkg::*;

module obi_rr_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_MASTERS-1:0]              m_req_i,
  output logic [NUM_MASTERS-1:0]              m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]              m_rvalid_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
  output logic                                s_req_o,
  input  logic                                s_gnt_i,
  output logic [ADDR_WIDTH-1:0]               s_addr_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_be_o,
  output logic [DATA_WIDTH-1:0]               s_wdata_o,
  input  logic                                s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]               s_rdata_i
`ifdef OBI_ARB_ERR_EN
  ,
  output logic                                err_o
`endif
);

  localparam int IDW = idw_f(NUM_MASTERS);
  localparam int BW  = DATA_WIDTH / 8;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] prio_ptr_q, prio_ptr_d;
  logic [IDW-1:0] hold_idx_q, hold_idx_d;

  logic [IDW-1:0] winner, sel, fifo_head;
  logic           found, sel_req, hs, push, pop;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           fifo_count_unused;
  int             cand;

  // The arbiter decides occupancy from the full/empty flags alone.
  assign fifo_count_unused = ^fifo_count;

  // Read data is a plain broadcast; m_rvalid_o tells each requester when it is theirs.
  assign m_rdata_o = {NUM_MASTERS{s_rdata_i}};

  always_comb begin
    winner     = '0;
    found      = 1'b0;
    cand       = 0;
    sel        = '0;
    sel_req    = 1'b0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    s_req_o    = 1'b0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    state_d    = state_q;
    prio_ptr_d = prio_ptr_q;
    hold_idx_d = hold_idx_q;

    // First requester at or after prio_ptr, wrapping modulo NUM_MASTERS.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(prio_ptr_q) + i) % NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && (j == cand) && m_req_i[j]) begin
          found  = 1'b1;
          winner = IDW'(j);
        end
      end
    end

    sel = (state_q == HOLD) ? hold_idx_q : winner;

    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (IDW'(j) == sel) begin
        sel_req   = m_req_i[j];
        s_addr_o  = m_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o    = m_we_i[j];
        s_be_o    = m_be_i[j*BW +: BW];
        s_wdata_o = m_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // A held requester already owns its FIFO slot, so only fresh arbitration
    // is blocked by a full FIFO (no same-cycle pop bypass).
    if (state_q == HOLD) s_req_o = sel_req && !rst_i;
    else                 s_req_o = (|m_req_i) && !fifo_full && !rst_i;

    hs   = s_req_o && s_gnt_i;
    push = hs;
    // An rvalid with nothing outstanding is dropped without touching the FIFO.
    pop  = s_rvalid_i && !fifo_empty && !rst_i;

    for (int j = 0; j < NUM_MASTERS; j++) begin
      m_gnt_o[j]    = hs && (IDW'(j) == sel);
      m_rvalid_o[j] = pop && (IDW'(j) == fifo_head);
    end

    if (hs) begin
      prio_ptr_d = (sel == IDW'(NUM_MASTERS - 1)) ? '0 : sel + IDW'(1);
    end

    case (state_q)
      ARB: begin
        if (s_req_o && !s_gnt_i) begin
          state_d    = HOLD;
          hold_idx_d = winner;
        end
      end
      HOLD: begin
        // Leave on the handshake, or abandon the slot if the requester withdrew.
        if (hs || !sel_req) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      prio_ptr_q <= '0;
      hold_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef OBI_ARB_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (s_rvalid_i && fifo_empty)           err_d = 1'b1;
    if ((state_q == HOLD) && !sel_req)      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q && !rst_i;
`endif

endmodule
